dma_bench_scheduler: RTL and testbench

Sequences benchmark descriptors onto the single PCIe DMA engine descriptor interface and shares it between C_NREQ independent benchmark requesters.
- Arbitration is round-robin. Each accepted request is a job: one address, one size, one iteration count.
- The block replays the job's descriptor until the iteration count is reached, in fixed-address or striding mode.
- At job end it reports the elapsed cycle count for the whole job.
- It sits between the benchmark control registers and the engine's descriptor inputs.

---
 rtl/dma_bench_pkg.sv | 15 +
 rtl/dma_bench_rr_arbiter.sv | 38 +++
 rtl/dma_bench_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dma_bench_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bench_pkg.sv
// Shared types and constants for the DMA benchmark descriptor scheduler.
package dma_bench_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int C_MODE_FIXED   = 1;
    localparam int C_MODE_STRIDE  = 2;
    localparam int C_CTRL_EOP_BIT = 3;

endpackage

// File: rtl/dma_bench_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module dma_bench_rr_arbiter #(
    parameter int C_NREQ = 4
) (
    input  logic [C_NREQ-1:0]         req,
    input  logic [$clog2(C_NREQ)-1:0] ptr,
    output logic [C_NREQ-1:0]         grant,
    output logic [$clog2(C_NREQ)-1:0] grant_idx,
    output logic                      any_req
);
    localparam int IDX_W = $clog2(C_NREQ);

    logic found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        // Upper pass covers ptr..top, lower pass wraps around to index 0.
        for (int i = 0; i < C_NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found     = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < C_NREQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
        any_req = found;
    end

endmodule

// File: rtl/dma_bench_scheduler.sv
// Shares one DMA descriptor interface between benchmark requesters; replays each
// granted job's descriptor niter times and reports the elapsed cycle count.
module dma_bench_scheduler
    import dma_bench_pkg::*;
#(
    parameter int C_NREQ   = 4,
    parameter int C_MODE   = 1,
    parameter int C_ITER_W = 32,
    parameter int C_CNT_W  = 48
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [C_NREQ-1:0]            REQ_VALID,
    input  logic [C_NREQ*64-1:0]         REQ_ADDR,
    input  logic [C_NREQ*64-1:0]         REQ_SIZE,
    input  logic [C_NREQ*C_ITER_W-1:0]   REQ_NITER,
    output logic [C_NREQ-1:0]            REQ_ACK,
    output logic [C_NREQ-1:0]            REQ_DONE,
    output logic                         ENGINE_VALID,
    output logic [63:0]                  ENGINE_ADDR,
    output logic [63:0]                  ENGINE_SIZE,
    input  logic [7:0]                   ENGINE_CONTROL_BYTE,
    output logic                         ELAPSED_VALID,
    output logic [$clog2(C_NREQ)-1:0]    ELAPSED_ID,
    output logic [C_CNT_W-1:0]           ELAPSED_CYCLES,
    output logic                         BUSY
);
    localparam int IDX_W  = $clog2(C_NREQ);
    localparam bit STRIDE = (C_MODE == C_MODE_STRIDE);

    logic [63:0]         req_addr  [C_NREQ];
    logic [63:0]         req_size  [C_NREQ];
    logic [C_ITER_W-1:0] req_niter [C_NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < C_NREQ; gi++) begin : g_unpack
            assign req_addr[gi]  = REQ_ADDR[64*gi +: 64];
            assign req_size[gi]  = REQ_SIZE[64*gi +: 64];
            assign req_niter[gi] = REQ_NITER[C_ITER_W*gi +: C_ITER_W];
        end
    endgenerate

    logic [C_NREQ-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    state_t              state_reg;
    logic [IDX_W-1:0]    ptr_reg;
    logic [IDX_W-1:0]    gnt_reg;
    logic [63:0]         addr_reg;
    logic [63:0]         size_reg;
    logic [C_ITER_W-1:0] niter_reg;
    logic [C_ITER_W-1:0] iter_reg;
    logic [C_CNT_W-1:0]  cnt_reg;
    logic [C_NREQ-1:0]   ack_reg;
    logic [C_NREQ-1:0]   done_reg;
    logic                valid_reg;
    logic                elapsed_valid_reg;
    logic [IDX_W-1:0]    elapsed_id_reg;
    logic [C_CNT_W-1:0]  elapsed_cycles_reg;
    logic                busy_reg;

    logic [C_ITER_W-1:0] iter_next;
    logic [C_CNT_W-1:0]  cnt_next;
    logic                eop;
    logic                unused_ctrl;

    assign eop         = ENGINE_CONTROL_BYTE[C_CTRL_EOP_BIT];
    assign unused_ctrl = ^(ENGINE_CONTROL_BYTE & ~(8'd1 << C_CTRL_EOP_BIT));
    assign iter_next   = iter_reg + 1'b1;
    // Elapsed counter saturates rather than wrapping on absurdly long jobs.
    assign cnt_next    = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

    dma_bench_rr_arbiter #(
        .C_NREQ(C_NREQ)
    ) u_arb (
        .req       (REQ_VALID),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg          <= IDLE;
            ptr_reg            <= '0;
            gnt_reg            <= '0;
            addr_reg           <= '0;
            size_reg           <= '0;
            niter_reg          <= '0;
            iter_reg           <= '0;
            cnt_reg            <= '0;
            ack_reg            <= '0;
            done_reg           <= '0;
            valid_reg          <= 1'b0;
            elapsed_valid_reg  <= 1'b0;
            elapsed_id_reg     <= '0;
            elapsed_cycles_reg <= '0;
            busy_reg           <= 1'b0;
        end else begin
            ack_reg           <= '0;
            done_reg          <= '0;
            elapsed_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        state_reg <= ISSUE;
                        gnt_reg   <= arb_idx;
                        addr_reg  <= req_addr[arb_idx];
                        size_reg  <= req_size[arb_idx];
                        niter_reg <= (req_niter[arb_idx] == '0) ? C_ITER_W'(1) : req_niter[arb_idx];
                        iter_reg  <= '0;
                        cnt_reg   <= '0;
                        ack_reg   <= arb_grant;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= cnt_next;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_next;
                    if (eop) begin
                        iter_reg <= iter_next;
                        if (iter_next == niter_reg) begin
                            state_reg          <= REPORT;
                            valid_reg          <= 1'b0;
                            done_reg[gnt_reg]  <= 1'b1;
                            elapsed_valid_reg  <= 1'b1;
                            elapsed_id_reg     <= gnt_reg;
                            elapsed_cycles_reg <= cnt_next;
                        end else if (STRIDE) begin
                            addr_reg <= addr_reg + size_reg;
                        end
                    end
                end
                REPORT: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ptr_reg   <= (gnt_reg == IDX_W'(C_NREQ - 1)) ? '0 : gnt_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign REQ_ACK        = ack_reg;
    assign REQ_DONE       = done_reg;
    assign ENGINE_VALID   = valid_reg;
    assign ENGINE_ADDR    = addr_reg;
    assign ENGINE_SIZE    = size_reg;
    assign ELAPSED_VALID  = elapsed_valid_reg;
    assign ELAPSED_ID     = elapsed_id_reg;
    assign ELAPSED_CYCLES = elapsed_cycles_reg;
    assign BUSY           = busy_reg;

endmodule

// File: tb/tb_dma_bench_scheduler.sv
// Directed bench: fixed-address and striding instances share one stimulus stream.
module tb_dma_bench_scheduler;

    localparam int NREQ   = 4;
    localparam int ITER_W = 32;
    localparam int CNT_W  = 48;

    logic                     CLK = 1'b0;
    logic                     RST_N;
    logic [NREQ-1:0]          REQ_VALID;
    logic [NREQ*64-1:0]       REQ_ADDR;
    logic [NREQ*64-1:0]       REQ_SIZE;
    logic [NREQ*ITER_W-1:0]   REQ_NITER;
    logic [7:0]               ENGINE_CONTROL_BYTE;

    logic [NREQ-1:0]  f_ack, f_done, s_ack, s_done;
    logic             f_valid, s_valid, f_evalid, s_evalid, f_busy, s_busy;
    logic [63:0]      f_addr, f_size, s_addr, s_size;
    logic [1:0]       f_eid, s_eid;
    logic [CNT_W-1:0] f_ecyc, s_ecyc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dma_bench_scheduler #(.C_NREQ(NREQ), .C_MODE(1), .C_ITER_W(ITER_W), .C_CNT_W(CNT_W)) dut_fixed (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE), .REQ_NITER(REQ_NITER), .REQ_ACK(f_ack), .REQ_DONE(f_done),
        .ENGINE_VALID(f_valid), .ENGINE_ADDR(f_addr), .ENGINE_SIZE(f_size),
        .ENGINE_CONTROL_BYTE(ENGINE_CONTROL_BYTE), .ELAPSED_VALID(f_evalid),
        .ELAPSED_ID(f_eid), .ELAPSED_CYCLES(f_ecyc), .BUSY(f_busy)
    );

    dma_bench_scheduler #(.C_NREQ(NREQ), .C_MODE(2), .C_ITER_W(ITER_W), .C_CNT_W(CNT_W)) dut_stride (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE), .REQ_NITER(REQ_NITER), .REQ_ACK(s_ack), .REQ_DONE(s_done),
        .ENGINE_VALID(s_valid), .ENGINE_ADDR(s_addr), .ENGINE_SIZE(s_size),
        .ENGINE_CONTROL_BYTE(ENGINE_CONTROL_BYTE), .ELAPSED_VALID(s_evalid),
        .ELAPSED_ID(s_eid), .ELAPSED_CYCLES(s_ecyc), .BUSY(s_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse end-of-operation in the n-th cycle from now, return in the cycle after it.
    task automatic eop_after(input int n);
        ENGINE_CONTROL_BYTE = 8'h00;
        repeat (n - 1) tick();
        ENGINE_CONTROL_BYTE = 8'h08;
        tick();
        ENGINE_CONTROL_BYTE = 8'h00;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] s, input logic [31:0] n);
        REQ_ADDR[64*i +: 64]         = a;
        REQ_SIZE[64*i +: 64]         = s;
        REQ_NITER[ITER_W*i +: ITER_W] = n;
    endtask

    initial begin
        RST_N = 1'b0;
        REQ_VALID = '0;
        REQ_ADDR = '0;
        REQ_SIZE = '0;
        REQ_NITER = '0;
        ENGINE_CONTROL_BYTE = 8'h00;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        check("rst_valid", f_valid, 0);
        check("rst_busy", f_busy, 0);
        check("rst_ack", f_ack, 0);
        check("rst_evalid", s_evalid, 0);
        check("rst_addr", f_addr, 0);
        RST_N = 1'b1;
        tick();

        // 1: fixed address, niter 3, EOP five cycles after each descriptor
        set_req(0, 64'h1000, 64'd256, 3);
        REQ_VALID = 4'b0001;
        tick();
        $display("t1 job start addr=0x%0h", f_addr);
        check("t1_ack", f_ack, 4'b0001);
        check("t1_valid_issue", f_valid, 1);
        check("t1_addr_issue", f_addr, 64'h1000);
        check("t1_size", f_size, 64'd256);
        check("t1_busy", f_busy, 1);
        REQ_VALID = 4'b0000;
        eop_after(6);
        check("t1_addr_it1", f_addr, 64'h1000);
        check("t1_stride_addr_it1", s_addr, 64'h1100);
        check("t1_done_it1", f_done, 0);
        eop_after(6);
        check("t1_addr_it2", f_addr, 64'h1000);
        check("t1_valid_it2", f_valid, 1);
        check("t1_done_it2", f_done, 0);
        eop_after(6);
        $display("t1 report id=%0d cycles=%0d", f_eid, f_ecyc);
        check("t1_done", f_done, 4'b0001);
        check("t1_evalid", f_evalid, 1);
        check("t1_eid", f_eid, 0);
        check("t1_ecyc", f_ecyc, 18);
        check("t1_valid_report", f_valid, 0);
        tick();
        check("t1_done_pulse", f_done, 0);
        check("t1_evalid_pulse", f_evalid, 0);
        check("t1_busy_idle", f_busy, 0);

        // 2: striding address wraps modulo 2^64
        set_req(0, 64'hFFFF_FFFF_FFFF_FF00, 64'h80, 3);
        REQ_VALID = 4'b0001;
        tick();
        check("t2_ack", s_ack, 4'b0001);
        check("t2_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FF00);
        REQ_VALID = 4'b0000;
        eop_after(2);
        check("t2_addr1", s_addr, 64'hFFFF_FFFF_FFFF_FF80);
        eop_after(2);
        check("t2_addr2", s_addr, 64'h0);
        check("t2_fixed_addr", f_addr, 64'hFFFF_FFFF_FFFF_FF00);
        check("t2_valid", s_valid, 1);
        eop_after(2);
        $display("t2 report id=%0d cycles=%0d", s_eid, s_ecyc);
        check("t2_done", s_done, 4'b0001);
        check("t2_ecyc", s_ecyc, 6);
        tick();

        // 3: three requesters at reset release, requester 0 keeps requesting
        RST_N = 1'b0;
        set_req(0, 64'h2000, 64'd64, 1);
        set_req(1, 64'h3000, 64'd64, 1);
        set_req(2, 64'h4000, 64'd64, 1);
        REQ_VALID = 4'b0111;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        check("t3_ack_a", f_ack, 4'b0001);
        check("t3_addr_a", f_addr, 64'h2000);
        eop_after(2);
        check("t3_done_a", f_done, 4'b0001);
        check("t3_ecyc_a", f_ecyc, 2);
        tick();
        check("t3_gap_idle", f_busy, 0);
        tick();
        check("t3_ack_b", f_ack, 4'b0010);
        check("t3_addr_b", f_addr, 64'h3000);
        REQ_VALID[1] = 1'b0;
        eop_after(2);
        check("t3_done_b", f_done, 4'b0010);
        tick();
        tick();
        check("t3_ack_c", f_ack, 4'b0100);
        check("t3_addr_c", f_addr, 64'h4000);
        REQ_VALID[2] = 1'b0;
        eop_after(2);
        check("t3_done_c", f_done, 4'b0100);
        check("t3_eid_c", f_eid, 2);
        tick();
        tick();
        $display("t3 fourth grant ack=%b", f_ack);
        check("t3_ack_d", f_ack, 4'b0001);
        REQ_VALID = 4'b0000;
        eop_after(2);
        check("t3_done_d", f_done, 4'b0001);
        tick();

        // 4: niter 0 behaves as one iteration
        set_req(3, 64'h5000, 64'd32, 0);
        REQ_VALID = 4'b1000;
        tick();
        check("t4_ack", f_ack, 4'b1000);
        REQ_VALID = 4'b0000;
        eop_after(2);
        $display("t4 report id=%0d cycles=%0d", f_eid, f_ecyc);
        check("t4_done", f_done, 4'b1000);
        check("t4_valid_low", f_valid, 0);
        check("t4_eid", f_eid, 3);
        check("t4_ecyc", f_ecyc, 2);
        tick();

        // 5: EOP during the ISSUE cycle is ignored
        set_req(1, 64'h6000, 64'd32, 2);
        REQ_VALID = 4'b0010;
        tick();
        check("t5_ack", f_ack, 4'b0010);
        REQ_VALID = 4'b0000;
        ENGINE_CONTROL_BYTE = 8'h08;
        tick();
        ENGINE_CONTROL_BYTE = 8'hF7;
        check("t5_valid_wait", f_valid, 1);
        eop_after(2);
        check("t5_done_early", f_done, 0);
        check("t5_valid_mid", f_valid, 1);
        eop_after(2);
        $display("t5 report id=%0d cycles=%0d", f_eid, f_ecyc);
        check("t5_done", f_done, 4'b0010);
        check("t5_ecyc", f_ecyc, 5);
        tick();

        // 6: reset mid-job aborts it, arbitration restarts from requester 0
        set_req(2, 64'h7000, 64'd64, 4);
        set_req(1, 64'h8000, 64'd64, 1);
        REQ_VALID = 4'b0100;
        tick();
        check("t6_ack", f_ack, 4'b0100);
        REQ_VALID = 4'b0110;
        eop_after(2);
        check("t6_valid_before", f_valid, 1);
        RST_N = 1'b0;
        #1;
        check("t6_rst_valid", f_valid, 0);
        check("t6_rst_busy", f_busy, 0);
        check("t6_rst_addr", f_addr, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check("t6_rel_done", f_done, 0);
        tick();
        $display("t6 post-reset grant ack=%b", f_ack);
        check("t6_regrant", f_ack, 4'b0010);
        check("t6_no_done", f_done, 0);
        check("t6_no_evalid", f_evalid, 0);
        REQ_VALID = 4'b0000;
        eop_after(2);
        check("t6_done", f_done, 4'b0010);
        check("t6_eid", f_eid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
